// File: rtl/foc_operand_fetch.sv
// foc_operand_fetch: fetches the A and B operands of an instruction from a
// constant ROM and/or a register file, both of which have one-cycle read
// latency. It then presents the operand bundle on a valid/ready output.
//
// Ports
//   c, r                    clock (rising edge), synchronous active-high reset
//   in_valid / in_ready     instruction handshake
//   in_a_sel, in_b_sel      operand source: 1 = constant ROM, 0 = register file
//   in_a_idx, in_b_idx      operand indices
//   in_op, in_dst           opcode and destination register (passed through)
//   const_addr / const_q    constant ROM read port (registered ROM)
//   reg_addr / reg_q        register file read port (registered read)
//   out_valid / out_ready   operand-bundle handshake
//   out_a, out_b, out_op, out_dst   operand bundle
module foc_operand_fetch #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          c,
  input  logic          r,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_a_sel,
  input  logic          in_b_sel,
  input  logic [AW-1:0] in_a_idx,
  input  logic [AW-1:0] in_b_idx,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_dst,
  output logic [AW-1:0] const_addr,
  input  logic [W-1:0]  const_q,
  output logic [AW-1:0] reg_addr,
  input  logic [W-1:0]  reg_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [3:0]    out_op,
  output logic [AW-1:0] out_dst
);

  typedef enum logic [2:0] {IDLE, RD1, CAP_A, CAP_B, DONE} state_t;

  state_t        state_q, state_d;
  logic          a_sel_q, a_sel_d;
  logic          b_sel_q, b_sel_d;
  logic [AW-1:0] a_idx_q, a_idx_d;
  logic [AW-1:0] b_idx_q, b_idx_d;
  logic [3:0]    op_q,    op_d;
  logic [AW-1:0] dst_q,   dst_d;
  logic [W-1:0]  out_a_q, out_a_d;
  logic [W-1:0]  out_b_q, out_b_d;

  logic          accept;
  logic          split;   // A and B come from different ports
  logic          pres_a;
  logic          pres_b;
  logic [W-1:0]  a_data;
  logic [W-1:0]  b_data;

  assign split  = (a_sel_q != b_sel_q);
  assign accept = in_valid && in_ready;
  assign a_data = a_sel_q ? const_q : reg_q;
  assign b_data = b_sel_q ? const_q : reg_q;

  // State and datapath registers
  always_ff @(posedge c) begin
    if (r) begin
      state_q <= IDLE;
      a_sel_q <= 1'b0;
      b_sel_q <= 1'b0;
      a_idx_q <= '0;
      b_idx_q <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      state_q <= state_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      a_idx_q <= a_idx_d;
      b_idx_q <= b_idx_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD1;
      RD1:     state_d = CAP_A;
      CAP_A:   state_d = split ? DONE : CAP_B;
      CAP_B:   state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? RD1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Field latching and operand capture
  always_comb begin
    a_sel_d = a_sel_q;
    b_sel_d = b_sel_q;
    a_idx_d = a_idx_q;
    b_idx_d = b_idx_q;
    op_d    = op_q;
    dst_d   = dst_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (accept) begin
      a_sel_d = in_a_sel;
      b_sel_d = in_b_sel;
      a_idx_d = in_a_idx;
      b_idx_d = in_b_idx;
      op_d    = in_op;
      dst_d   = in_dst;
    end
    if (state_q == CAP_A) out_a_d = a_data;
    if ((state_q == CAP_A && split) || state_q == CAP_B) out_b_d = b_data;
  end

  // Outputs: read addresses come only from state and latched fields
  always_comb begin
    pres_a     = (state_q == RD1);
    pres_b     = (state_q == RD1 && split) || (state_q == CAP_A && !split);
    const_addr = '1;
    reg_addr   = '0;
    if (!r) begin
      if (pres_a) begin
        if (a_sel_q) const_addr = a_idx_q;
        else         reg_addr   = a_idx_q;
      end
      if (pres_b) begin
        if (b_sel_q) const_addr = b_idx_q;
        else         reg_addr   = b_idx_q;
      end
    end
    in_ready  = !r && (state_q == IDLE || (state_q == DONE && out_ready));
    out_valid = (state_q == DONE);
    out_a     = out_a_q;
    out_b     = out_b_q;
    out_op    = op_q;
    out_dst   = dst_q;
  end

endmodule

// File: tb/tb_foc_operand_fetch.sv
module tb_foc_operand_fetch;

  logic        c = 1'b0;
  logic        r;
  logic        in_valid, in_ready;
  logic        in_a_sel, in_b_sel;
  logic [4:0]  in_a_idx, in_b_idx, in_dst;
  logic [3:0]  in_op;
  logic [4:0]  const_addr, reg_addr;
  logic [31:0] const_q, reg_q;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_dst;

  int tests = 0;
  int fails = 0;

  logic [31:0] rom  [32];
  logic [31:0] regf [32];

  always #5 c = ~c;

  foc_operand_fetch #(.W(32), .AW(5)) dut (
    .c(c), .r(r), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_a_idx(in_a_idx),
    .in_b_idx(in_b_idx), .in_op(in_op), .in_dst(in_dst),
    .const_addr(const_addr), .const_q(const_q),
    .reg_addr(reg_addr), .reg_q(reg_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_dst(out_dst)
  );

  // Registered ROM and register file, one-cycle read latency
  always @(posedge c) begin
    const_q <= rom[const_addr];
    reg_q   <= regf[reg_addr];
  end

  typedef struct {
    logic        a_sel, b_sel;
    logic [4:0]  a_idx, b_idx;
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [31:0] exp_a, exp_b;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  dst;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_a_sel = v.a_sel; in_b_sel = v.b_sel;
    in_a_idx = v.a_idx; in_b_idx = v.b_idx;
    in_op    = v.op;    in_dst   = v.dst;
  endtask

  task automatic run_instr(input vec_t v, input string nm);
    int lat;
    int to;
    to = 0;
    @(negedge c);
    while (!in_ready && to < 20) begin @(negedge c); to++; end
    check({nm, "_ready"}, in_ready, 1);
    drive(v);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge c);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge c); lat++; end
    check({nm, "_lat"}, lat, v.lat);
    check({nm, "_a"},   out_a, v.exp_a);
    check({nm, "_b"},   out_b, v.exp_b);
    check({nm, "_op"},  {28'd0, out_op}, {28'd0, v.op});
    check({nm, "_dst"}, {27'd0, out_dst}, {27'd0, v.dst});
  endtask

  initial begin
    vec_t v;
    exp_t q[$];
    exp_t e;
    int cyc;

    for (int i = 0; i < 32; i++) begin
      rom[i]  = 32'h5A00_0000 | i;
      regf[i] = 32'hA500_0000 | i;
    end
    rom[5'h02] = 32'h3f2a_aaab;
    rom[5'h0f] = 32'h40c9_0fdb;
    rom[5'h10] = 32'h3fc9_0fdb;
    rom[5'h1f] = 32'h0000_0000;
    regf[5'h03] = 32'h4120_0000;

    //            a_sel b_sel a_idx  b_idx  op    dst    exp_a          exp_b          lat
    vecs[0] = '{1'b1, 1'b0, 5'h02, 5'h03, 4'h3, 5'h07, 32'h3f2a_aaab, 32'h4120_0000, 3};
    vecs[1] = '{1'b1, 1'b1, 5'h0f, 5'h10, 4'h5, 5'h1e, 32'h40c9_0fdb, 32'h3fc9_0fdb, 4};
    vecs[2] = '{1'b0, 1'b1, 5'h05, 5'h02, 4'ha, 5'h01, 32'hA500_0005, 32'h3f2a_aaab, 3};
    vecs[3] = '{1'b0, 1'b0, 5'h03, 5'h09, 4'hf, 5'h1f, 32'h4120_0000, 32'hA500_0009, 4};
    vecs[4] = '{1'b0, 1'b0, 5'h0c, 5'h0c, 4'h1, 5'h00, 32'hA500_000c, 32'hA500_000c, 4};
    vecs[5] = '{1'b1, 1'b1, 5'h1f, 5'h07, 4'h8, 5'h10, 32'h0000_0000, 32'h5A00_0007, 4};

    // Reset
    r = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    v = vecs[0]; drive(v);
    repeat (2) @(negedge c);
    check("rst_in_ready",   in_ready, 0);
    check("rst_const_addr", const_addr, 5'h1f);
    check("rst_reg_addr",   reg_addr, 0);
    check("rst_out_valid",  out_valid, 0);
    check("rst_out_a",      out_a, 0);
    check("rst_out_b",      out_b, 0);
    check("rst_out_op",     out_op, 0);
    check("rst_out_dst",    out_dst, 0);
    r = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors
    foreach (vecs[i]) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Same-port constant pair: address sequence and 4-cycle latency
    @(negedge c);
    v = vecs[1]; drive(v); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge c); in_valid = 1'b0;
    check("cc_addr1", const_addr, 5'h0f);
    @(negedge c);
    check("cc_addr2", const_addr, 5'h10);
    @(negedge c);
    check("cc_addr3", const_addr, 5'h1f);
    check("cc_valid3", out_valid, 0);
    @(negedge c);
    check("cc_valid4", out_valid, 1);
    check("cc_a", out_a, 32'h40c9_0fdb);
    check("cc_b", out_b, 32'h3fc9_0fdb);

    // Back-pressure in DONE
    @(negedge c);
    v = '{1'b0, 1'b1, 5'h04, 5'h10, 4'h6, 5'h0b, 32'h0, 32'h0, 3};
    drive(v); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge c); in_valid = 1'b0;
    @(negedge c);
    for (int k = 0; k < 5; k++) begin
      @(negedge c);
      check("stall_valid",    out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_a",        out_a, 32'hA500_0004);
      check("stall_b",        out_b, 32'h3fc9_0fdb);
      check("stall_op",       out_op, 4'h6);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    @(negedge c);
    check("stall_valid_fall", out_valid, 0);

    // Reset during CAP_A discards the instruction
    v = vecs[0]; drive(v); in_valid = 1'b1;
    @(negedge c); in_valid = 1'b0;
    @(negedge c);
    r = 1'b1;
    @(negedge c);
    check("midrst_const_addr", const_addr, 5'h1f);
    check("midrst_in_ready",   in_ready, 0);
    r = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_valid", out_valid, 0);
      @(negedge c);
    end
    run_instr(vecs[2], "after_rst");

    // Back-to-back, different ports: out_valid at cycles 3 and 6
    @(negedge c);
    v = vecs[0]; drive(v); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge c);
    v = '{1'b0, 1'b1, 5'h05, 5'h0f, 4'h9, 5'h02, 32'h0, 32'h0, 3}; drive(v);
    @(negedge c);
    @(negedge c);
    check("b2b_valid3", out_valid, 1);
    check("b2b_ready3", in_ready, 1);
    check("b2b_a1", out_a, 32'h3f2a_aaab);
    check("b2b_b1", out_b, 32'h4120_0000);
    @(negedge c);
    in_valid = 1'b0;
    check("b2b_valid4", out_valid, 0);
    @(negedge c);
    check("b2b_valid5", out_valid, 0);
    @(negedge c);
    check("b2b_valid6", out_valid, 1);
    check("b2b_a2", out_a, 32'hA500_0005);
    check("b2b_b2", out_b, 32'h40c9_0fdb);
    check("b2b_op2", out_op, 4'h9);

    // Randomized traffic against a scoreboard
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge c);
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("rnd_spurious_valid", out_valid, 0);
        end else begin
          check("rnd_a",   out_a, q[0].a);
          check("rnd_b",   out_b, q[0].b);
          check("rnd_op",  {28'd0, out_op}, {28'd0, q[0].op});
          check("rnd_dst", {27'd0, out_dst}, {27'd0, q[0].dst});
          if (!q[0].seen) begin
            check("rnd_lat", cyc - q[0].acc, q[0].lat);
            q[0].seen = 1'b1;
          end
        end
      end else if (q.size() > 0) begin
        if (q[0].seen) check("rnd_valid_dropped", out_valid, 1);
        else if (cyc - q[0].acc > 6) begin
          check("rnd_timeout", out_valid, 1);
          void'(q.pop_front());
        end
      end
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a_sel  = 1'($urandom_range(0, 1));
      in_b_sel  = 1'($urandom_range(0, 1));
      in_a_idx  = 5'($urandom_range(0, 31));
      in_b_idx  = 5'($urandom_range(0, 31));
      in_op     = 4'($urandom_range(0, 15));
      in_dst    = 5'($urandom_range(0, 31));
      #1;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e.a    = in_a_sel ? rom[in_a_idx] : regf[in_a_idx];
        e.b    = in_b_sel ? rom[in_b_idx] : regf[in_b_idx];
        e.op   = in_op;
        e.dst  = in_dst;
        e.acc  = cyc;
        e.lat  = (in_a_sel != in_b_sel) ? 3 : 4;
        e.seen = 1'b0;
        q.push_back(e);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge c);
    check("rnd_drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/foc_operand_fetch.md
FOC_OPERAND_FETCH -- requirements
Module: foc_operand_fetch

Interface
REQ-001 Parameters SHALL be: W, 32, operand width (IEEE-754 single); AW, 5, index width of constant ROM and register file.
REQ-002 Port c  in  1  clock; all logic SHALL be rising-edge of c; one clock only.
REQ-003 Port r  in  1  reset, synchronous, active-high.
REQ-004 Ports in_valid in 1, in_ready out 1: instruction handshake, transfer when both high at a c edge.
REQ-005 Ports in_a_sel in 1, in_b_sel in 1: operand source, 1 = constant ROM, 0 = register file.
REQ-006 Ports in_a_idx in AW, in_b_idx in AW: operand index; in_op in 4: opcode; in_dst in AW: destination register.
REQ-007 Port const_addr out AW: constant ROM address; const_q in W: ROM data, registered ROM, one-cycle read latency.
REQ-008 Port reg_addr out AW: register file read address; reg_q in W: read data, one-cycle latency.
REQ-009 Ports out_valid out 1, out_ready in 1: operand-bundle handshake; out_a out W, out_b out W, out_op out 4, out_dst out AW.

Function
REQ-010 On accept, in_* fields SHALL be latched; const_addr/reg_addr SHALL be driven combinationally from state and latched fields only.
REQ-011 States SHALL be IDLE, RD1, CAP_A, CAP_B, DONE.
REQ-012 IDLE: in_ready=1; accept -> RD1.
REQ-013 RD1: present A index on A's port; if B uses the other port, present B index on that port too; -> CAP_A.
REQ-014 CAP_A: at cycle end capture A from its port's q; if B on other port capture B same edge and -> DONE; else present B index on shared port and -> CAP_B.
REQ-015 CAP_B: at cycle end capture B from shared port's q; -> DONE.
REQ-016 Latency: out_valid SHALL rise 3 cycles after accept edge (different ports) or 4 cycles (both operands same port).
REQ-017 DONE: out_valid=1; out_a, out_b, out_op, out_dst SHALL stay stable until out_ready.
REQ-018 in_ready SHALL be 1 in IDLE, or in DONE while out_ready=1; 0 otherwise.
REQ-019 DONE with out_ready=1 and in_valid=1: new instruction accepted same edge, -> RD1 (back-to-back); with in_valid=0 -> IDLE.
REQ-020 When a port is unused in a state, const_addr SHALL be 5'h1f (zero constant) and reg_addr SHALL be 0.
REQ-021 Identical indices for A and B on same port SHALL still take two reads (no dedup).
REQ-022 Operand values SHALL pass bit-exact; no arithmetic, no width change.

Reset
REQ-023 r=1 at an edge SHALL force state IDLE, out_valid=0, out_a=0, out_b=0, out_op=0, out_dst=0, latched fields 0.
REQ-024 Reset mid-operation SHALL discard the pending instruction; no out_valid results from it.
REQ-025 During and after reset const_addr=5'h1f, reg_addr=0, in_ready=0 while r=1, 1 first cycle after.

Verification
REQ-026 A=const 5'h02, B=reg 5'h03 (model reg_q=32'h4120_0000), out_ready=1 -> out_valid 3 cycles after accept, out_a=32'h3f2a_aaab, out_b=32'h4120_0000.
REQ-027 A=const 5'h0f, B=const 5'h10 -> const_addr sequence 0f,10; out_valid at 4 cycles; out_a=32'h40c9_0fdb, out_b=32'h3fc9_0fdb.
REQ-028 out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> one transfer, out_valid falls next cycle.
REQ-029 r pulsed in CAP_A -> out_valid never asserts for that instruction; const_addr=5'h1f next cycle; next instruction completes normally.
REQ-030 Two instructions back-to-back, in_valid and out_ready held high -> second accepted in first's DONE cycle; out_valid pulses at cycles 3 and 6 (different-port case).
